// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage pipeline: opcodes, control-vector layout
// and the ID/EX pipeline word.
package pipeline_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CTRL_W = 10;
  localparam int unsigned IDEX_W = CTRL_W + 3 * XLEN;

  // Opcodes handled by the ID stage; funct is left to EX.
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  // Control-vector bit positions.
  localparam int unsigned CTRL_REGDST   = 9;
  localparam int unsigned CTRL_ALUSRC   = 8;
  localparam int unsigned CTRL_MEMTOREG = 7;
  localparam int unsigned CTRL_REGWRITE = 6;
  localparam int unsigned CTRL_MEMREAD  = 5;
  localparam int unsigned CTRL_MEMWRITE = 4;
  localparam int unsigned CTRL_BRANCH   = 3;
  localparam int unsigned CTRL_ALUOP_HI = 2;
  localparam int unsigned CTRL_ALUOP_LO = 1;
  localparam int unsigned CTRL_JUMP     = 0;

  // ID/EX field offsets (LSB of each field).
  localparam int unsigned IDEX_CTRL_LSB = 3 * XLEN;
  localparam int unsigned IDEX_PC_LSB   = 2 * XLEN;
  localparam int unsigned IDEX_RD1_LSB  = XLEN;
  localparam int unsigned IDEX_RD2_LSB  = 0;

  // Control vectors per instruction class.
  localparam logic [CTRL_W-1:0] CTRL_RTYPE_V = 10'h244;
  localparam logic [CTRL_W-1:0] CTRL_LW_V    = 10'h1E0;
  localparam logic [CTRL_W-1:0] CTRL_SW_V    = 10'h110;
  localparam logic [CTRL_W-1:0] CTRL_BEQ_V   = 10'h00A;
  localparam logic [CTRL_W-1:0] CTRL_ADDI_V  = 10'h140;
  localparam logic [CTRL_W-1:0] CTRL_J_V     = 10'h001;
  localparam logic [CTRL_W-1:0] CTRL_NOP_V   = 10'h000;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   read_data1;
    logic [XLEN-1:0]   read_data2;
  } id_ex_t;

endpackage

// File: rtl/id_control.sv
// Main decoder: opcode to 10-bit control vector; unknown opcodes become a bubble.
module id_control
  import pipeline_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  output logic [CTRL_W-1:0] ctrl_c
);

  always_comb begin
    ctrl_c = CTRL_NOP_V;
    case (op)
      OP_RTYPE: ctrl_c = CTRL_RTYPE_V;
      OP_LW:    ctrl_c = CTRL_LW_V;
      OP_SW:    ctrl_c = CTRL_SW_V;
      OP_BEQ:   ctrl_c = CTRL_BEQ_V;
      OP_ADDI:  ctrl_c = CTRL_ADDI_V;
      OP_J:     ctrl_c = CTRL_J_V;
      default:  ctrl_c = CTRL_NOP_V;
    endcase
  end

endmodule

// File: rtl/id_decode_stage.sv
// ID stage: splits IF/ID, decodes control, reads rs/rt (r0 reads as zero)
// and registers the result into the ID/EX word.
module id_decode_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*SIZE-1:0]       IF_ID,
  input  logic [SIZE*SIZE-1:0]    registerFile,
  output logic [CTRL_W+3*SIZE-1:0] ID_EX
);

  logic [SIZE-1:0]   pc_plus4;
  logic [SIZE-1:0]   instr;
  logic [OP_W-1:0]   op;
  logic [REG_W-1:0]  rs;
  logic [REG_W-1:0]  rt;
  logic [REG_W-1:0]  rd;
  logic [REG_W-1:0]  shamt;
  logic [5:0]        funct;
  logic [CTRL_W-1:0] ctrl_c;
  logic [SIZE-1:0]   read_data1_c;
  logic [SIZE-1:0]   read_data2_c;
  id_ex_t            id_ex_d;
  logic              unused_fields_c;

  assign pc_plus4 = IF_ID[2*SIZE-1:SIZE];
  assign instr    = IF_ID[SIZE-1:0];

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];

  // rd/shamt/funct are decoded downstream, not here.
  assign unused_fields_c = ^{rd, shamt, funct};

  id_control u_id_control (
    .op     (op),
    .ctrl_c (ctrl_c)
  );

  // Register reads straight off the bus; index 0 is hard-wired to zero.
  always_comb begin
    read_data1_c = '0;
    read_data2_c = '0;
    if (rs != '0) read_data1_c = registerFile[32'(rs) * SIZE +: SIZE];
    if (rt != '0) read_data2_c = registerFile[32'(rt) * SIZE +: SIZE];
  end

  always_comb begin
    id_ex_d            = '0;
    id_ex_d.ctrl       = ctrl_c;
    id_ex_d.pc_plus4   = pc_plus4;
    id_ex_d.read_data1 = read_data1_c;
    id_ex_d.read_data2 = read_data2_c;
  end

  // ID/EX pipeline register; reset inserts a bubble.
  always_ff @(posedge clk) begin
    if (rst) ID_EX <= '0;
    else     ID_EX <= id_ex_d;
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: driver queues expected ID/EX words,
// monitor compares one per rising edge.
module tb_id_decode_stage;

  localparam int unsigned SIZE = 32;
  localparam int unsigned W    = 10 + 3 * SIZE;

  typedef struct {
    logic [W-1:0] exp;
    string        name;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [2*SIZE-1:0]    if_id;
  logic [SIZE*SIZE-1:0] reg_bus;
  logic [W-1:0]         id_ex;

  exp_t           sb_q[$];
  logic [31:0]    rf[32];
  int             checks = 0;
  int             errors = 0;

  id_decode_stage #(.SIZE(SIZE)) dut (
    .clk          (clk),
    .rst          (rst),
    .IF_ID        (if_id),
    .registerFile (reg_bus),
    .ID_EX        (id_ex)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_instr(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] low);
    return {op, rs, rt, low};
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : rf[idx];
  endfunction

  task automatic set_reg(input int idx, input logic [31:0] v);
    rf[idx] = v;
    reg_bus[idx*32 +: 32] = v;
  endtask

  // Drive one cycle of stimulus and queue what the next edge must produce.
  task automatic step(input string name, input logic r, input logic [31:0] pc,
                      input logic [31:0] instr, input logic [9:0] ctrl);
    exp_t e;
    @(negedge clk);
    rst   = r;
    if_id = {pc, instr};
    e.name = name;
    e.exp  = r ? '0 : {ctrl, pc, rd_model(instr[25:21]), rd_model(instr[20:16])};
    sb_q.push_back(e);
  endtask

  // Monitor: one comparison per rising edge while expectations are pending.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        checks++;
        if (id_ex !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, id_ex, e.exp);
        end
      end
    end
  end

  initial begin
    logic [31:0] r_instr;
    rst     = 1'b1;
    if_id   = {32'h1234_5678, 32'h8C64_0000};
    reg_bus = '0;
    for (int i = 0; i < 32; i++) set_reg(i, 32'(i));

    step("reset", 1'b1, 32'hCAFE_0004, 32'hFFFF_FFFF, 10'h000);

    r_instr = 32'b000000_00100_00110_01000_00000_010000;
    step("rtype", 1'b0, 32'd4, r_instr, 10'h244);
    for (int k = 0; k < 3; k++) step("rtype_hold", 1'b0, 32'd4, r_instr, 10'h244);

    step("lw",   1'b0, 32'h100, mk_instr(6'b100011, 5'd3, 5'd9, 16'h0010), 10'h1E0);
    step("sw",   1'b0, 32'h104, mk_instr(6'b101011, 5'd3, 5'd9, 16'h0020), 10'h110);
    step("beq",  1'b0, 32'h108, mk_instr(6'b000100, 5'd3, 5'd9, 16'hFFFC), 10'h00A);
    step("j",    1'b0, 32'h10C, mk_instr(6'b000010, 5'd1, 5'd2, 16'h0040), 10'h001);
    step("addi", 1'b0, 32'h110, mk_instr(6'b001000, 5'd7, 5'd8, 16'h0005), 10'h140);
    step("unknown_op", 1'b0, 32'h114, mk_instr(6'b111111, 5'd31, 5'd30, 16'h0000), 10'h000);

    set_reg(0, 32'hDEAD_BEEF);
    step("r0_both", 1'b0, 32'h200, mk_instr(6'b000000, 5'd0, 5'd0, 16'h0820), 10'h244);
    step("r0_rs",   1'b0, 32'h204, mk_instr(6'b100011, 5'd0, 5'd5, 16'h0000), 10'h1E0);

    // Bus value at the edge is what gets captured.
    @(negedge clk);
    set_reg(4, 32'hA5A5_0004);
    set_reg(6, 32'h5A5A_0006);
    step("new_regs", 1'b0, 32'd8, r_instr, 10'h244);

    step("mid_rtype", 1'b0, 32'd4, r_instr, 10'h244);
    step("mid_reset", 1'b1, 32'd4, r_instr, 10'h244);
    step("post_reset", 1'b0, 32'd4, r_instr, 10'h244);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Instruction-decode (ID) stage of the 5-stage MIPS-style pipeline; sits between the IF/ID register and the EX stage.
- Splits the IF/ID word into next-PC and instruction, decodes the opcode into a 10-bit control vector, and reads rs/rt from a flattened register-file bus.
- Registers everything into the ID/EX pipeline word on the rising clock edge.

Parameters:
- SIZE, 32, data/address/instruction width and register count. Only SIZE=32 is supported, because register fields are 5 bits.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- IF_ID  input  2*SIZE  [2*SIZE-1:SIZE] = PC+4 from IF; [SIZE-1:0] = instruction
- registerFile  input  SIZE*SIZE  packed array of SIZE registers; register r occupies bits [r*SIZE +: SIZE]
- ID_EX  output  10+3*SIZE (106)  registered pipeline word; layout given under Behaviour

Behaviour:
- Instruction fields:
  - op = instr[31:26], rs = instr[25:21], rt = instr[20:16], rd = instr[15:11], shamt = instr[10:6], funct = instr[5:0].
  - funct, rd, shamt and imm are not forwarded; this stage does not decode funct (EX handles the ALU function).
- ID_EX layout (MSB to LSB):
  - [105:96] control vector
  - [95:64] PC+4, passed through unchanged
  - [63:32] readData1 = registerFile[rs]
  - [31:0] readData2 = registerFile[rt]
- Control vector bit order:
  - [9] RegDst, [8] ALUSrc, [7] MemtoReg, [6] RegWrite, [5] MemRead, [4] MemWrite, [3] Branch, [2:1] ALUOp, [0] Jump.
- Decode table (opcode -> control):
  - 000000 R-type -> 10'h244 (RegDst, RegWrite, ALUOp=10)
  - 100011 lw -> 10'h1E0
  - 101011 sw -> 10'h110
  - 000100 beq -> 10'h00A (Branch, ALUOp=01)
  - 001000 addi -> 10'h140
  - 000010 j -> 10'h001
  - any other opcode -> 10'h000 (bubble/NOP; no writes)
- Register 0: readData is forced to 0 whenever the index is 0, regardless of registerFile contents.
- Reads are combinational from the registerFile bus; the bus value sampled at the clock edge is captured, so there is no write-through.
- Latency: ID_EX reflects the IF_ID/registerFile values present at the preceding rising edge, i.e. 1 cycle.
- Reset:
  - rst high at a rising edge -> ID_EX = 0 (all control bits clear = bubble).
  - Reset has priority over new input.
  - Reset mid-stream squashes the in-flight decode; the next edge with rst low captures new input normally.
- Steady input: ID_EX stays constant across repeated edges.
- Undefined (X) input bits propagate; no X-masking is required.
- No stall/flush ports in this block; hazard handling lives elsewhere.

Decomposition:
- Shared package (pipeline_pkg):
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - control-bit index constants and the CTRL_W=10 width
  - ID_EX field offsets
  - control-vector localparams for each instruction class
- One combinational sub-module, id_control: opcode in, 10-bit control out.
- The top level does field extraction, register selection with the r0 override, and the pipeline register.

Test Plan:
- Reset: rst=1 for one edge with arbitrary inputs -> ID_EX == 106'h0.
- R-type:
  - Setup: registerFile[i]=i for all i; IF_ID = {32'd4, 000000_00100_00110_01000_00000_010000}.
  - After first edge: ID_EX = {10'h244, 32'd4, 32'd4, 32'd6}.
  - Value holds over 3 further edges.
- lw:
  - Setup: instr op=100011, rs=3, rt=9, registerFile[i]=i, PC+4=32'h100.
  - Required: ID_EX = {10'h1E0, 32'h100, 32'd3, 32'd9}.
  - Repeat with op=101011 (sw) -> 10'h110, op=000100 (beq) -> 10'h00A.
- j and addi: control 10'h001 and 10'h140 respectively; unknown opcode 6'b111111 -> control 10'h000.
- r0 override: registerFile[0]=32'hDEADBEEF, rs=0, rt=0 -> readData1 = readData2 = 0.
- Reset mid-stream: valid R-type captured, then rst=1 for one edge -> ID_EX=0; rst=0 on the next edge -> R-type word reappears.
